shifter_op_ctrl: RTL and testbench
==================================

// Module: shifter_op_ctrl
//
// PURPOSE
//  Sequencer for the 1-bit gate / 4-bit shifter datapath. It accepts one command per
//  valid/ready handshake and runs one of two kinds of operation:
//  - a bitwise gate operation (AND/OR/NAND/NOR/XOR/XNOR) in one cycle, or
//  - an iterative logical shift, one bit position per clock.
//  The result is held on a valid/ready output until the consumer takes it.
//  Sits between the test/command source and the gate/shifter datapath.
//
// PARAMETERS
//  WIDTH  4  operand/result width in bits
//  CNT_W  2  shift-amount width; must equal clog2(WIDTH), so amounts run 0..WIDTH-1
//  OPC_W  8  width of the completed-operation counter
//
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      controller can accept a command
//  cmd_op     in   3      0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 SHL, 7 SHR
//  cmd_a      in   WIDTH  operand A (the shift source for ops 6/7)
//  cmd_b      in   WIDTH  operand B (ignored for ops 6/7)
//  cmd_amt    in   CNT_W  shift amount (ignored for ops 0-5)
//  res_valid  out  1      result available
//  res_ready  in   1      consumer takes the result
//  res_data   out  WIDTH  result
//  busy       out  1      state != IDLE
//  op_count   out  OPC_W  number of completed result handshakes, wraps modulo 2^OPC_W
//
// BEHAVIOUR
//  - Reset (async, active-high):
//    - state=IDLE; res_valid=0, res_data=0, op_count=0, internal acc/cnt=0.
//    - cmd_ready=0 while rst=1.
//    - Reset asserted mid-operation aborts it; the partial result is discarded and
//      no result handshake occurs.
//  - States:
//    - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op, a, b, amt -> EXEC.
//    - EXEC, ops 0-5: at the next edge res_data=f(a,b), where f is the bitwise op -> DONE.
//    - EXEC, ops 6-7: at each edge, if cnt==0 then res_data=acc -> DONE;
//      otherwise acc shifts by 1 (SHL: {acc[W-2:0],0}; SHR: {0,acc[W-1:1]}) and cnt-=1.
//    - DONE: res_valid=1. res_data stays stable until res_valid&res_ready.
//      At that edge: res_valid=0, op_count+=1, -> IDLE.
//  - Latency, counted from the accept edge E0:
//    - gate ops: res_valid high after E1.
//    - shift of amt n: res_valid high after E(n+1).
//  - cmd_ready=0 in EXEC and DONE; a cmd_valid arriving then is held off, not dropped.
//  - Back-to-back: cmd_ready=1 the cycle after a result handshake (IDLE).
//    One idle cycle always separates commands.
//  - res_ready high before DONE has no effect. res_ready in the same cycle that
//    res_valid rises completes the handshake at the following edge.
//  - op_count wraps from 2^OPC_W-1 to 0 with no side effect.
//  - Shift ops vacate bits to 0. amt=0 returns cmd_a unchanged.
//
// STRUCTURE
//  - shifter_ctrl_defs.vh:
//    - opcode localparams (OP_AND..OP_SHR);
//    - state encodings (S_IDLE=2'd0, S_EXEC=2'd1, S_DONE=2'd2);
//    - default WIDTH.
//  - Sub-module shift1_unit: combinational, one-position logical shift, dir input,
//    WIDTH parameter.
//  - The FSM, counters and bitwise op mux stay in this module.
//
// TESTING
//  1. Reset then release: res_valid=0, op_count=0, busy=0, cmd_ready=1.
//  2. op=3 (NOR), a=4'b0011, b=4'b0101, res_ready=1:
//     res_data=4'b1000 one edge after accept; op_count=1.
//  3. op=6 (SHL), a=4'b0111, amt=3: res_valid rises 4 edges after accept, res_data=4'b1000.
//     op=7 (SHR), a=4'b1010, amt=0: res_data=4'b1010 after 1 edge.
//  4. Backpressure: hold res_ready=0 for 5 cycles after res_valid; pulse cmd_valid meanwhile.
//     res_data stays stable, cmd_ready=0, command not accepted until the handshake completes.
//  5. Assert rst mid-SHL (amt=3, after 2 edges): immediate IDLE, res_valid=0,
//     op_count unchanged (0).
//  6. 256 back-to-back op=0 (AND) commands with res_ready=1: op_count wraps to 0.
//     Each result equals a&b, checked against a reference model.

Source files
------------

// File: rtl/shifter_op_ctrl_pkg.sv
// Shared definitions for the gate/shifter sequencer: opcodes, FSM states, default width.
package shifter_op_ctrl_pkg;

   localparam int DEF_WIDTH = 4;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_NOR  = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;
   localparam logic [2:0] OP_SHL  = 3'd6;
   localparam logic [2:0] OP_SHR  = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Opcodes 6 and 7 are the only iterative operations.
   function automatic logic is_shift(input logic [2:0] op);
      return op[2] & op[1];
   endfunction

endpackage

// File: rtl/shifter_op_ctrl_shift1_unit.sv
// One-position logical shift; i_dir=0 shifts left, i_dir=1 shifts right, vacated bit is 0.
module shift1_unit #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_dir,
   output logic [WIDTH-1:0] o_data
);

   always_comb begin
      o_data = '0;
      if (i_dir) o_data = {1'b0, i_data[WIDTH-1:1]};
      else       o_data = {i_data[WIDTH-2:0], 1'b0};
   end

endmodule

// File: rtl/shifter_op_ctrl.sv
// Command sequencer: one-cycle bitwise gate ops or bit-serial logical shifts, with a
// held valid/ready result port and a wrapping completed-operation counter.
module shifter_op_ctrl
   import shifter_op_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = 2,
   parameter int OPC_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [CNT_W-1:0] cmd_amt,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             busy,
   output logic [OPC_W-1:0] op_count,
   output logic [1:0]       dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both
   // high; the source holds its payload stable while valid is high and ready is low.

   state_t           r_state;
   state_t           w_next_state;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_b;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_res_data;
   logic             r_res_valid;
   logic [OPC_W-1:0] r_op_count;
   logic [WIDTH-1:0] w_gate;
   logic [WIDTH-1:0] w_shifted;
   logic             w_accept;
   logic             w_is_shift;

   assign cmd_ready  = (r_state == S_IDLE) & ~rst;
   assign w_accept   = cmd_valid & cmd_ready;
   assign w_is_shift = is_shift(r_op);
   assign res_valid  = r_res_valid;
   assign res_data   = r_res_data;
   assign busy       = (r_state != S_IDLE);
   assign op_count   = r_op_count;
   assign dbg_state  = r_state;

   shift1_unit #(.WIDTH(WIDTH)) u_shift1 (
      .i_data (r_acc),
      .i_dir  (r_op == OP_SHR),
      .o_data (w_shifted)
   );

   always_comb begin
      w_gate = '0;
      case (r_op)
         OP_AND:  w_gate = r_acc & r_b;
         OP_OR:   w_gate = r_acc | r_b;
         OP_NAND: w_gate = ~(r_acc & r_b);
         OP_NOR:  w_gate = ~(r_acc | r_b);
         OP_XOR:  w_gate = r_acc ^ r_b;
         OP_XNOR: w_gate = ~(r_acc ^ r_b);
         default: w_gate = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next_state = S_EXEC;
         S_EXEC: if (!w_is_shift || (r_cnt == '0)) w_next_state = S_DONE;
         S_DONE: if (res_ready) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Operand A doubles as the shift accumulator, so gate ops read it from r_acc too.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op        <= OP_AND;
         r_acc       <= '0;
         r_b         <= '0;
         r_cnt       <= '0;
         r_res_data  <= '0;
         r_res_valid <= 1'b0;
         r_op_count  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op  <= cmd_op;
                  r_acc <= cmd_a;
                  r_b   <= cmd_b;
                  r_cnt <= cmd_amt;
               end
            end
            S_EXEC: begin
               if (w_is_shift) begin
                  if (r_cnt == '0) begin
                     r_res_data  <= r_acc;
                     r_res_valid <= 1'b1;
                  end else begin
                     r_acc <= w_shifted;
                     r_cnt <= r_cnt - 1'b1;
                  end
               end else begin
                  r_res_data  <= w_gate;
                  r_res_valid <= 1'b1;
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_op_count  <= r_op_count + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shifter_op_ctrl.sv
// Randomized self-checking bench for shifter_op_ctrl against a behavioural result/latency model.
module tb_shifter_op_ctrl;

   localparam int W  = 4;
   localparam int CW = 2;
   localparam int OW = 8;

   logic          clk;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_op;
   logic [W-1:0]  cmd_a;
   logic [W-1:0]  cmd_b;
   logic [CW-1:0] cmd_amt;
   logic          res_valid;
   logic          res_ready;
   logic [W-1:0]  res_data;
   logic          busy;
   logic [OW-1:0] op_count;
   logic [1:0]    dbg_state;

   int            checks;
   int            errors;
   int            exp_count;
   logic [W-1:0]  exp_q[$];

   shifter_op_ctrl #(.WIDTH(W), .CNT_W(CW), .OPC_W(OW)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_amt   (cmd_amt),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .busy      (busy),
      .op_count  (op_count),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: what the operation means arithmetically, truncated to W bits.
   function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic [CW-1:0] amt);
      logic [2*W-1:0] wide;
      wide = {{W{1'b0}}, a} << amt;
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return ~(a & b);
         3'd3: return ~(a | b);
         3'd4: return a ^ b;
         3'd5: return ~(a ^ b);
         3'd6: return wide[W-1:0];
         default: return a >> amt;
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] op, input logic [CW-1:0] amt);
      return (op >= 3'd6) ? int'(amt) + 1 : 1;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      cmd_valid = 1'b0;
      res_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      exp_count = 0;
      exp_q.delete();
   endtask

   // One full command: accept, wait for result, optional backpressure, handshake.
   task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [CW-1:0] amt, input int hold, input bit rr_early,
                          input bit pulse);
      int           n;
      int           lat;
      logic [W-1:0] exp;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_amt   = amt;
      res_ready = rr_early;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      exp_q.push_back(ref_result(op, a, b, amt));
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 3'($urandom);
      cmd_a     = W'($urandom);
      cmd_b     = W'($urandom);
      cmd_amt   = CW'($urandom);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!res_valid && lat < 20);
      chk("latency", 32'(lat), 32'(ref_latency(op, amt)));
      exp = exp_q.pop_front();
      chk("res_data", 32'(res_data), 32'(exp));
      chk("busy_done", 32'(busy), 32'd1);
      if (!rr_early) begin
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (pulse) begin
               cmd_valid = 1'($urandom_range(0, 1));
               cmd_op    = 3'($urandom);
               cmd_a     = W'($urandom);
            end
            @(posedge clk);
            #1;
            chk("hold_data", 32'(res_data), 32'(exp));
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
         end
         @(negedge clk);
         cmd_valid = 1'b0;
         res_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      exp_count++;
      chk("hs_valid_low", 32'(res_valid), 32'd0);
      chk("op_count", 32'(op_count), 32'(exp_count % (1 << OW)));
      chk("idle_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      exp_count = 0;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_amt   = '0;
      res_ready = 1'b0;

      do_reset();
      #1;
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_op_count", 32'(op_count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_res_data", 32'(res_data), 32'd0);

      run_cmd(3'd3, 4'b0011, 4'b0101, 2'd0, 0, 1'b1, 1'b0);
      run_cmd(3'd6, 4'b0111, 4'b0000, 2'd3, 0, 1'b1, 1'b0);
      run_cmd(3'd7, 4'b1010, 4'b1111, 2'd0, 0, 1'b1, 1'b0);
      run_cmd(3'd4, 4'b1100, 4'b1010, 2'd2, 5, 1'b0, 1'b1);
      run_cmd(3'd7, 4'b1111, 4'b0000, 2'd3, 5, 1'b0, 1'b1);

      for (int i = 0; i < 40; i++)
         run_cmd(3'($urandom), W'($urandom), W'($urandom), CW'($urandom),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      // Reset in the middle of a 3-position shift.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 3'd6;
      cmd_a     = 4'b0111;
      cmd_amt   = 2'd3;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      exp_count = 0;
      chk("abort_res_valid", 32'(res_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_op_count", 32'(op_count), 32'd0);
      chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("abort_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_release_ready", 32'(cmd_ready), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      chk("abort_no_result", 32'(res_valid), 32'd0);
      chk("abort_count_held", 32'(op_count), 32'd0);
      @(negedge clk);
      res_ready = 1'b0;

      for (int i = 0; i < 256; i++)
         run_cmd(3'd0, W'($urandom), W'($urandom), CW'($urandom), 0, 1'b1, 1'b0);
      chk("op_count_wrap", 32'(op_count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=%0d exp=%0d", checks, 0);
      $fatal(1, "timeout");
   end

endmodule
